quadrature_encoder_emulator: RTL and testbench



---
 rtl/quadrature_encoder_emulator.sv | 165 ++++++++++++++++
 tb/tb_quadrature_encoder_emulator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B encoder emulator.
// Produces A/B phase waveforms from a commanded tick period and direction,
// either continuously (RUN) or for a fixed number of edges (MOVE), and keeps
// an emulated position count that a downstream decoder should reproduce.
module quadrature_encoder_emulator #(
    parameter int PERIOD_WIDTH = 32,
    parameter int COUNT_WIDTH  = 32,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    direction,
    input  logic [PERIOD_WIDTH-1:0] tick_period,
    input  logic                    move_start,
    input  logic [15:0]             move_ticks,
    input  logic                    count_clear,
    output logic                    encoder_a,
    output logic                    encoder_b,
    output logic [COUNT_WIDTH-1:0]  tick_count,
    output logic                    step_pulse,
    output logic                    busy,
    output logic                    move_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_MOVE = 2'd2;

    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE_P = PERIOD_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  ONE_C = COUNT_WIDTH'(1);

    logic [1:0]              state;
    logic [PERIOD_WIDTH-1:0] interval;    // clocks elapsed in the current interval
    logic [PERIOD_WIDTH-1:0] period_q;    // period latched at interval start
    logic                    dir_q;       // direction latched at interval start
    logic [15:0]             remaining;   // edges still owed by the active move

    logic [PERIOD_WIDTH-1:0] eff_period;
    logic                    interval_done;
    logic                    start_move;
    logic                    start_run;
    logic                    stop;
    logic                    finish;
    logic                    edge_now;
    logic                    next_a;
    logic                    next_b;

    // Clamp the requested period and decide the A/B successor for the latched direction.
    always_comb begin
        eff_period    = (tick_period < MIN_P) ? MIN_P : tick_period;
        interval_done = (interval == (period_q - ONE_P));
        // Forward walks 00->10->11->01; reverse walks the same ring backwards.
        next_a        = dir_q ? ~encoder_b : encoder_b;
        next_b        = dir_q ? encoder_a  : ~encoder_a;
    end

    // Control decisions for this cycle; move_start outranks enable, and a busy move ignores both.
    always_comb begin
        start_move = 1'b0;
        start_run  = 1'b0;
        stop       = 1'b0;
        finish     = 1'b0;
        edge_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (move_start) begin
                    start_move = 1'b1;
                end else if (enable) begin
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (move_start) begin
                    start_move = 1'b1;
                end else if (!enable) begin
                    stop = 1'b1;
                end else if (interval_done) begin
                    edge_now = 1'b1;
                end
            end
            ST_MOVE: begin
                if (remaining == 16'd0) begin
                    finish = 1'b1;
                end else if (interval_done) begin
                    edge_now = 1'b1;
                end
            end
            default: begin
                stop = 1'b1;
            end
        endcase
    end

    // State, interval timing, phase outputs and move handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            interval   <= '0;
            period_q   <= MIN_P;
            dir_q      <= 1'b0;
            remaining  <= 16'd0;
            encoder_a  <= 1'b0;
            encoder_b  <= 1'b0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            move_done  <= 1'b0;
            if (start_move) begin
                state     <= ST_MOVE;
                busy      <= 1'b1;
                remaining <= move_ticks;
                interval  <= '0;
                period_q  <= eff_period;
                dir_q     <= direction;
            end else if (start_run) begin
                state    <= ST_RUN;
                interval <= '0;
                period_q <= eff_period;
                dir_q    <= direction;
            end else if (stop) begin
                // Immediate stop: A/B hold, the partial interval is discarded.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                interval <= '0;
            end else if (finish) begin
                busy      <= 1'b0;
                move_done <= 1'b1;
                interval  <= '0;
                if (enable) begin
                    state    <= ST_RUN;
                    period_q <= eff_period;
                    dir_q    <= direction;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (edge_now) begin
                encoder_a  <= next_a;
                encoder_b  <= next_b;
                step_pulse <= 1'b1;
                interval   <= '0;
                period_q   <= eff_period;
                dir_q      <= direction;
                if (state == ST_MOVE) begin
                    remaining <= remaining - 16'd1;
                end
            end else if (state != ST_IDLE) begin
                interval <= interval + ONE_P;
            end
        end
    end

    // Emulated position; a clear in the same cycle as an edge discards that edge's step.
    always_ff @(posedge clk) begin
        if (reset || count_clear) begin
            tick_count <= '0;
        end else if (edge_now) begin
            tick_count <= dir_q ? (tick_count + ONE_C) : (tick_count - ONE_C);
        end
    end

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Bench for quadrature_encoder_emulator: deadline-based reference model,
// per-cycle output comparison, directed scenarios with literal expectations,
// and a behavioural quadrature decoder on the A/B outputs.
module tb_quadrature_encoder_emulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        direction = 1'b0;
    logic [31:0] tick_period = 32'd4;
    logic        move_start = 1'b0;
    logic [15:0] move_ticks = 16'd0;
    logic        count_clear = 1'b0;
    logic        encoder_a;
    logic        encoder_b;
    logic [31:0] tick_count;
    logic        step_pulse;
    logic        busy;
    logic        move_done;

    always #5 clk = ~clk;

    quadrature_encoder_emulator #(
        .PERIOD_WIDTH(32),
        .COUNT_WIDTH (32),
        .MIN_PERIOD  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .tick_period(tick_period),
        .move_start (move_start),
        .move_ticks (move_ticks),
        .count_clear(count_clear),
        .encoder_a  (encoder_a),
        .encoder_b  (encoder_b),
        .tick_count (tick_count),
        .step_pulse (step_pulse),
        .busy       (busy),
        .move_done  (move_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode 0=idle, 1=run, 2=move. Edges are scheduled as absolute cycle deadlines.
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    longint      cyc     = 0;
    longint      m_next  = 0;
    longint      m_per   = 2;
    int          m_mode  = 0;
    int          m_phase = 0;
    int          m_left  = 0;
    bit          m_dir   = 1'b0;
    bit          m_step  = 1'b0;
    bit          m_done  = 1'b0;
    logic [31:0] m_count = 32'd0;

    task automatic start_interval();
        m_per  = (tick_period < 32'd2) ? 2 : longint'(tick_period);
        m_dir  = direction;
        m_next = cyc + m_per;
    endtask

    always @(posedge clk) begin
        bit edge_now;
        cyc++;
        m_step   = 1'b0;
        m_done   = 1'b0;
        edge_now = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_phase = 0;
            m_count = 32'd0;
            m_left  = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (move_start) begin
                        m_mode = 2; m_left = int'(move_ticks); start_interval();
                    end else if (enable) begin
                        m_mode = 1; start_interval();
                    end
                end
                1: begin
                    if (move_start) begin
                        m_mode = 2; m_left = int'(move_ticks); start_interval();
                    end else if (!enable) begin
                        m_mode = 0;
                    end else if (cyc == m_next) begin
                        edge_now = 1'b1;
                    end
                end
                default: begin
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        if (enable) begin
                            m_mode = 1; start_interval();
                        end else begin
                            m_mode = 0;
                        end
                    end else if (cyc == m_next) begin
                        edge_now = 1'b1;
                        m_left--;
                    end
                end
            endcase
            if (edge_now) begin
                m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
                m_count = m_dir ? m_count + 32'd1 : m_count - 32'd1;
                m_step  = 1'b1;
                start_interval();
            end
            if (count_clear) m_count = 32'd0;
        end
    end

    always @(posedge clk) begin
        #1;
        check("encoder_a",  encoder_a,  ab_tab[m_phase][1]);
        check("encoder_b",  encoder_b,  ab_tab[m_phase][0]);
        check("tick_count", tick_count, m_count);
        check("step_pulse", step_pulse, m_step);
        check("busy",       busy,       (m_mode == 2));
        check("move_done",  move_done,  m_done);
    end

    // ---------------- loopback decoder ----------------
    int         dec_count = 0;
    int         dec_err   = 0;
    logic [1:0] dec_prev  = 2'b00;

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [1:0] cur;
        int d;
        cur = {encoder_a, encoder_b};
        if (cur !== dec_prev) begin
            d = (phase_of(cur) - phase_of(dec_prev) + 4) % 4;
            if (d == 1) dec_count++;
            else if (d == 3) dec_count--;
            else dec_err++;
            dec_prev = cur;
        end
    end

    task automatic run_move(input int ticks, input bit dir, input int per, input int budget);
        bit seen;
        seen        = 1'b0;
        move_ticks  = 16'(ticks);
        direction   = dir;
        tick_period = 32'(per);
        move_start  = 1'b1;
        @(negedge clk);
        move_start = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (move_done) seen = 1'b1;
            else @(negedge clk);
        end
        check("move_done_seen", seen, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int busy_n;
        int done_n;
        int step_n;
        int done_idx;
        int dec0;

        repeat (3) @(negedge clk);
        check("reset_count", tick_count, 0);
        check("reset_ab", {encoder_a, encoder_b}, 2'b00);
        check("reset_busy", busy, 0);

        // Continuous forward run, period 4.
        reset = 1'b0; enable = 1'b1; direction = 1'b1; tick_period = 32'd4;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3)  check("t1_pre_edge_ab", {encoder_a, encoder_b}, 2'b00);
            if (i == 4) begin
                check("t1_first_ab", {encoder_a, encoder_b}, 2'b10);
                check("t1_first_step", step_pulse, 1);
                check("t1_first_count", tick_count, 1);
            end
            if (i == 8)  check("t1_second_ab", {encoder_a, encoder_b}, 2'b11);
            if (i == 16) begin
                check("t1_count4", tick_count, 4);
                check("t1_ab_wrap", {encoder_a, encoder_b}, 2'b00);
            end
        end

        // Reverse before the sixth edge: it lands forward, later edges go back.
        repeat (7) @(negedge clk);
        direction = 1'b0;
        repeat (9) @(negedge clk);
        check("t2_count4", tick_count, 4);
        check("t2_ab", {encoder_a, encoder_b}, 2'b00);

        // Stop and clear, then a reverse counted move of 5 at period 3.
        enable = 1'b0; count_clear = 1'b1;
        @(negedge clk);
        count_clear = 1'b0;
        repeat (2) @(negedge clk);
        move_ticks = 16'd5; direction = 1'b0; tick_period = 32'd3; move_start = 1'b1;
        busy_n = 0; done_n = 0; step_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
            done_n += int'(move_done);
            step_n += int'(step_pulse);
            move_start = (i == 6);
            move_ticks = (i == 6) ? 16'd10 : 16'd5;
        end
        check("t3_busy_cycles", busy_n, 16);
        check("t3_done_pulses", done_n, 1);
        check("t3_edges", step_n, 5);
        check("t3_count_neg5", tick_count, 32'hFFFF_FFFB);
        check("t3_ab", {encoder_a, encoder_b}, 2'b01);

        // Zero-length move.
        move_ticks = 16'd0; move_start = 1'b1;
        busy_n = 0; step_n = 0; done_idx = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            move_start = 1'b0;
            busy_n += int'(busy);
            step_n += int'(step_pulse);
            if (move_done && done_idx < 0) done_idx = i;
        end
        check("t4_busy_cycles", busy_n, 1);
        check("t4_edges", step_n, 0);
        check("t4_done_delay", done_idx, 1);

        // Period 0 clamps to 2; clear coincides with the third edge.
        enable = 1'b1; direction = 1'b1; tick_period = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 6) begin
                check("t5_clear_count", tick_count, 0);
                check("t5_clear_ab", {encoder_a, encoder_b}, 2'b11);
                check("t5_clear_step", step_pulse, 1);
            end
            if (i == 7) check("t5_gap_step", step_pulse, 0);
            if (i == 8) begin
                check("t5_next_count", tick_count, 1);
                check("t5_next_ab", {encoder_a, encoder_b}, 2'b01);
            end
            count_clear = (i == 5);
        end

        // Loopback: 1000 forward then 400 reverse edges at period 2.
        enable = 1'b0; count_clear = 1'b1;
        @(negedge clk);
        count_clear = 1'b0;
        dec0 = dec_count;
        run_move(1000, 1'b1, 2, 2500);
        run_move(400, 1'b0, 2, 1200);
        check("t6_count600", tick_count, 600);
        check("t6_decoder600", dec_count - dec0, 600);
        check("t6_decoder_errors", dec_err, 0);

        // Reset in the middle of a move.
        move_ticks = 16'd10; direction = 1'b1; tick_period = 32'd4; move_start = 1'b1;
        @(negedge clk);
        move_start = 1'b0;
        repeat (14) @(negedge clk);
        check("t7_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_ab", {encoder_a, encoder_b}, 2'b00);
        check("t7_busy", busy, 0);
        check("t7_count", tick_count, 0);
        check("t7_step", step_pulse, 0);
        done_n = 0;
        for (int i = 0; i < 30; i++) begin
            done_n += int'(move_done);
            @(negedge clk);
        end
        check("t7_no_done", done_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
